// File: rtl/hangman_main.sv
// hangman_main: two-keypad Hangman core. The host spells a secret word with
// multi-tap keys, the player then guesses letters against it. Game progress
// is shown on two 16-character LCD rows per side and on RGB status LEDs.
module hangman_main #(
    parameter int DEBOUNCE = 8,
    parameter int WORD_LEN = 5,
    parameter int MAX_MISS = 6
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         role_switch,
    input  logic [3:0]   input_row_host,
    input  logic [3:0]   input_row_player,
    output logic         red,
    output logic         green,
    output logic         blue,
    output logic         error,
    output logic         msg_sent,
    output logic [127:0] host_row1,
    output logic [127:0] host_row2,
    output logic [127:0] play_row1,
    output logic [127:0] play_row2
);
    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam int LW = $clog2(WORD_LEN + 1);
    localparam logic [39:0] TXT_WORD   = "WORD:";
    localparam logic [55:0] TXT_LETTER = "LETTER:";
    localparam logic [47:0] TXT_GUESS  = "GUESS:";
    localparam logic [39:0] TXT_MISS   = "MISS:";

    typedef enum logic [1:0] {PH_SET, PH_GUESS, PH_WIN, PH_LOSE} phase_t;

    phase_t              phase_q, phase_d;
    logic [3:0]          hostMeta_q, hostSync_q, playMeta_q, playSync_q;
    logic [3:0]          cand_q;
    logic [CW-1:0]       cnt_q;
    logic                armed_q, role_q;
    logic [LW-1:0]       count_q, count_d;
    logic [3:0]          miss_q, miss_d;
    logic [1:0]          pendGrp_q, pendGrp_d;
    logic [3:0]          pendIdx_q, pendIdx_d;
    logic [7:0]          word_q [WORD_LEN];
    logic [7:0]          word_d [WORD_LEN];
    logic [WORD_LEN-1:0] revealed_q, revealed_d, hitMask;
    logic [25:0]         guessed_q, guessed_d;
    logic                started_q, started_d, msgSent_q, msgSent_d, error_q, error_d;
    logic [3:0]          keyBus;
    logic                roleChange, stableHit, keyOneHot, pressEvt;
    logic [7:0]          pendCh;
    logic [4:0]          letterNum;
    logic [1:0]          keyGrp;
    logic [7:0]          h1C [16];
    logic [7:0]          h2C [16];
    logic [7:0]          p1C [16];
    logic [7:0]          p2C [16];

    // Letter shown for a multi-tap group (1=R0, 2=R1, 3=R2) and tap index; space when none.
    function automatic logic [7:0] letterOf(input logic [1:0] grp, input logic [3:0] idx);
        logic [7:0] ch;
        ch = 8'h20;
        case (grp)
            2'd1: case (idx)
                4'd0: ch = "A";  4'd1: ch = "E";  4'd2: ch = "I";  4'd3: ch = "O";
                4'd4: ch = "U";  default: ch = 8'h20;
            endcase
            2'd2: case (idx)
                4'd0: ch = "J";  4'd1: ch = "K";  4'd2: ch = "L";  4'd3: ch = "M";
                4'd4: ch = "N";  4'd5: ch = "B";  4'd6: ch = "C";  4'd7: ch = "D";
                4'd8: ch = "F";  4'd9: ch = "G";  4'd10: ch = "H"; default: ch = 8'h20;
            endcase
            2'd3: case (idx)
                4'd0: ch = "P";  4'd1: ch = "Q";  4'd2: ch = "R";  4'd3: ch = "S";
                4'd4: ch = "T";  4'd5: ch = "V";  4'd6: ch = "W";  4'd7: ch = "X";
                4'd8: ch = "Y";  4'd9: ch = "Z";  default: ch = 8'h20;
            endcase
            default: ch = 8'h20;
        endcase
        return ch;
    endfunction

    // Index of the last letter in a group, where tapping wraps back to the first.
    function automatic logic [3:0] grpLast(input logic [1:0] grp);
        case (grp)
            2'd1:    return 4'd4;
            2'd2:    return 4'd10;
            default: return 4'd9;
        endcase
    endfunction

    // The live keypad depends on phase and role; finished games listen to nothing.
    assign keyBus = (phase_q == PH_SET)   ? (role_switch ? playSync_q : hostSync_q) :
                    (phase_q == PH_GUESS) ? (role_switch ? hostSync_q : playSync_q) : 4'b0000;
    assign roleChange = (role_switch != role_q);
    assign keyOneHot  = (cand_q != 4'b0000) && ((cand_q & (cand_q - 4'b0001)) == 4'b0000);
    assign stableHit  = !roleChange && (keyBus == cand_q) && (cnt_q == CW'(DEBOUNCE - 2));
    assign pressEvt   = stableHit && armed_q && keyOneHot;
    assign pendCh     = letterOf(pendGrp_q, pendIdx_q);
    assign letterNum  = 5'(pendCh - 8'h41);
    assign keyGrp     = cand_q[3] ? 2'd1 : (cand_q[2] ? 2'd2 : 2'd3);

    // Two-flop synchronizers for both keypad row buses.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hostMeta_q <= '0; hostSync_q <= '0; playMeta_q <= '0; playSync_q <= '0;
        end else begin
            hostMeta_q <= input_row_host;   hostSync_q <= hostMeta_q;
            playMeta_q <= input_row_player; playSync_q <= playMeta_q;
        end
    end

    // Debouncer: a pattern must hold steady; a press needs a settled release before it re-arms.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cand_q <= '0; cnt_q <= '0; armed_q <= 1'b1; role_q <= 1'b0;
        end else begin
            role_q <= role_switch;
            if (roleChange) begin
                cand_q <= '0; cnt_q <= '0; armed_q <= 1'b0;
            end else if (keyBus != cand_q) begin
                cand_q <= keyBus; cnt_q <= '0;
            end else begin
                if (cnt_q != CW'(DEBOUNCE - 1)) cnt_q <= cnt_q + 1'b1;
                if (stableHit && cand_q == 4'b0000) armed_q <= 1'b1;
                else if (pressEvt)                  armed_q <= 1'b0;
            end
        end
    end

    // Game state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            phase_q <= PH_SET; count_q <= '0; miss_q <= '0; pendGrp_q <= '0; pendIdx_q <= '0;
            revealed_q <= '0; guessed_q <= '0; started_q <= 1'b0; msgSent_q <= 1'b0; error_q <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++) word_q[i] <= 8'h20;
        end else begin
            phase_q <= phase_d; count_q <= count_d; miss_q <= miss_d; pendGrp_q <= pendGrp_d;
            pendIdx_q <= pendIdx_d; revealed_q <= revealed_d; guessed_q <= guessed_d;
            started_q <= started_d; msgSent_q <= msgSent_d; error_q <= error_d; word_q <= word_d;
        end
    end

    // Next-state: multi-tap entry, word building in SET, guess scoring in GUESS.
    always_comb begin
        phase_d = phase_q; count_d = count_q; miss_d = miss_q; pendGrp_d = pendGrp_q;
        pendIdx_d = pendIdx_q; revealed_d = revealed_q; guessed_d = guessed_q;
        started_d = started_q; msgSent_d = msgSent_q; error_d = 1'b0; word_d = word_q;
        hitMask = '0;
        if (roleChange) begin
            pendGrp_d = 2'd0; pendIdx_d = 4'd0;
        end else if (pressEvt) begin
            started_d = 1'b1;
            if (cand_q[0]) begin
                if (pendGrp_q == 2'd0) begin
                    error_d = 1'b1;
                end else begin
                    pendGrp_d = 2'd0; pendIdx_d = 4'd0;
                    if (phase_q == PH_SET) begin
                        for (int i = 0; i < WORD_LEN; i++)
                            if (count_q == LW'(i)) word_d[i] = pendCh;
                        count_d = count_q + LW'(1);
                        if (count_q == LW'(WORD_LEN - 1)) begin
                            phase_d = PH_GUESS; msgSent_d = 1'b1; revealed_d = '0;
                        end
                    end else if (guessed_q[letterNum]) begin
                        error_d = 1'b1;
                    end else begin
                        guessed_d[letterNum] = 1'b1;
                        for (int i = 0; i < WORD_LEN; i++) hitMask[i] = (word_q[i] == pendCh);
                        if (hitMask != '0) begin
                            revealed_d = revealed_q | hitMask;
                            if (&revealed_d) phase_d = PH_WIN;
                        end else begin
                            miss_d = miss_q + 4'd1;
                            if (miss_q == 4'(MAX_MISS - 1)) phase_d = PH_LOSE;
                        end
                    end
                end
            end else if (pendGrp_q == keyGrp) begin
                pendIdx_d = (pendIdx_q == grpLast(keyGrp)) ? 4'd0 : pendIdx_q + 4'd1;
            end else begin
                pendGrp_d = keyGrp; pendIdx_d = 4'd0;
            end
        end
    end

    // LCD text: rows stay blank until play starts; a lost game shows the whole word.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            h1C[i] = 8'h20; h2C[i] = 8'h20; p1C[i] = 8'h20; p2C[i] = 8'h20;
        end
        if (started_q) begin
            for (int i = 0; i < 5; i++) h1C[i] = TXT_WORD[39-8*i -: 8];
            for (int i = 0; i < WORD_LEN; i++)
                if (LW'(i) < count_q) h1C[5+i] = word_q[i];
            for (int i = 0; i < 7; i++) h2C[i] = TXT_LETTER[55-8*i -: 8];
            if (phase_q == PH_SET) h2C[7] = pendCh;
        end
        if (phase_q != PH_SET) begin
            for (int i = 0; i < 6; i++) p1C[i] = TXT_GUESS[47-8*i -: 8];
            for (int i = 0; i < WORD_LEN; i++)
                p1C[6+i] = (revealed_q[i] || phase_q == PH_LOSE) ? word_q[i] : 8'h5F;
            for (int i = 0; i < 5; i++) p2C[i] = TXT_MISS[39-8*i -: 8];
            p2C[5] = 8'h30 + {4'b0000, miss_q};
            if (phase_q == PH_GUESS) p2C[7] = pendCh;
        end
        for (int i = 0; i < 16; i++) begin
            host_row1[127-8*i -: 8] = h1C[i];
            host_row2[127-8*i -: 8] = h2C[i];
            play_row1[127-8*i -: 8] = p1C[i];
            play_row2[127-8*i -: 8] = p2C[i];
        end
    end

    assign blue     = started_q && (phase_q == PH_SET || phase_q == PH_GUESS);
    assign green    = (phase_q == PH_WIN);
    assign red      = (phase_q == PH_LOSE);
    assign error    = error_q;
    assign msg_sent = msgSent_q;
endmodule

// File: tb/tb_hangman_main.sv
// tb_hangman_main: directed Hangman games; every expected output snapshot is
// queued as a press is issued and matched whenever the DUT outputs change.
module tb_hangman_main;
    localparam int HOLD = 20;
    localparam logic [3:0] KEY_R0 = 4'b1000;
    localparam logic [3:0] KEY_R1 = 4'b0100;
    localparam logic [3:0] KEY_R2 = 4'b0010;
    localparam logic [3:0] KEY_R3 = 4'b0001;

    logic         clk, nRst, role_switch;
    logic [3:0]   input_row_host, input_row_player;
    logic         red, green, blue, error, msg_sent;
    logic [127:0] host_row1, host_row2, play_row1, play_row2;

    typedef struct packed {
        logic [127:0] h1;
        logic [127:0] h2;
        logic [127:0] p1;
        logic [127:0] p2;
        logic         red;
        logic         green;
        logic         blue;
        logic         err;
        logic         msg;
    } snap_t;

    snap_t expQ[$];
    snap_t prevSnap;
    int    assertCount = 0;
    int    failCount = 0;

    bit    started, inGuess, expRed, expGreen, expBlue, expErr, expMsg;
    string hostWord, guessStr;
    byte   pend, missCh;

    hangman_main dut (
        .clk(clk), .nRst(nRst), .role_switch(role_switch),
        .input_row_host(input_row_host), .input_row_player(input_row_player),
        .red(red), .green(green), .blue(blue), .error(error), .msg_sent(msg_sent),
        .host_row1(host_row1), .host_row2(host_row2),
        .play_row1(play_row1), .play_row2(play_row2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rowOf(input string s);
        logic [127:0] r;
        r = {16{8'h20}};
        for (int i = 0; i < s.len() && i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic snap_t currentSnap();
        snap_t s;
        s.h1 = host_row1; s.h2 = host_row2; s.p1 = play_row1; s.p2 = play_row2;
        s.red = red; s.green = green; s.blue = blue; s.err = error; s.msg = msg_sent;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] req, input bit isRow);
        assertCount++;
        if (act !== req) begin
            failCount++;
            if (isRow) $display("[TB] FAIL %s: actual \"%s\" required \"%s\" at %0t", name, act, req, $time);
            else       $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic compareSnap(input snap_t req, input snap_t act);
        checkOutput("host_row1", act.h1, req.h1, 1'b1);
        checkOutput("host_row2", act.h2, req.h2, 1'b1);
        checkOutput("play_row1", act.p1, req.p1, 1'b1);
        checkOutput("play_row2", act.p2, req.p2, 1'b1);
        checkOutput("red",       {127'd0, act.red},   {127'd0, req.red},   1'b0);
        checkOutput("green",     {127'd0, act.green}, {127'd0, req.green}, 1'b0);
        checkOutput("blue",      {127'd0, act.blue},  {127'd0, req.blue},  1'b0);
        checkOutput("error",     {127'd0, act.err},   {127'd0, req.err},   1'b0);
        checkOutput("msg_sent",  {127'd0, act.msg},   {127'd0, req.msg},   1'b0);
    endtask

    // Queue the display the DUT should show after the next output change.
    task automatic pushExp();
        snap_t s;
        s.h1 = started ? rowOf({"WORD:", hostWord}) : {16{8'h20}};
        s.h2 = started ? rowOf("LETTER:") : {16{8'h20}};
        if (started && !inGuess) s.h2[71 -: 8] = pend;
        s.p1 = inGuess ? rowOf({"GUESS:", guessStr}) : {16{8'h20}};
        s.p2 = inGuess ? rowOf("MISS:") : {16{8'h20}};
        if (inGuess) begin
            s.p2[87 -: 8] = missCh;
            s.p2[71 -: 8] = pend;
        end
        s.red = expRed; s.green = expGreen; s.blue = expBlue; s.err = expErr; s.msg = expMsg;
        expQ.push_back(s);
    endtask

    // An error press shows one cycle with error high, then the same display without it.
    task automatic pushErr();
        expErr = 1'b1; pushExp();
        expErr = 1'b0; pushExp();
    endtask

    task automatic applyStimulus(input bit onPlayer, input logic [3:0] key, input int holdCycles);
        @(posedge clk); #2;
        if (onPlayer) input_row_player = key;
        else          input_row_host   = key;
        repeat (holdCycles) @(posedge clk);
        #2;
        input_row_player = 4'b0000;
        input_row_host   = 4'b0000;
        repeat (HOLD) @(posedge clk);
    endtask

    task automatic tap(input bit onPlayer, input logic [3:0] key, input string seq);
        for (int i = 0; i < seq.len(); i++) begin
            pend = seq[i];
            pushExp();
            applyStimulus(onPlayer, key, HOLD);
        end
    endtask

    task automatic submitOk(input bit onPlayer);
        pend = 8'h20;
        pushExp();
        applyStimulus(onPlayer, KEY_R3, HOLD);
    endtask

    task automatic flipRole(input logic val);
        @(posedge clk); #2;
        role_switch = val;
        repeat (HOLD) @(posedge clk);
    endtask

    task automatic resetState();
        started = 0; inGuess = 0; expRed = 0; expGreen = 0; expBlue = 0; expErr = 0; expMsg = 0;
        hostWord = ""; guessStr = ""; pend = 8'h20; missCh = "0";
    endtask

    task automatic doReset();
        snap_t rs;
        resetState();
        nRst = 1'b0; role_switch = 1'b0; input_row_host = '0; input_row_player = '0;
        repeat (2) @(posedge clk);
        #2 nRst = 1'b1;
        @(negedge clk);
        rs.h1 = {16{8'h20}}; rs.h2 = {16{8'h20}}; rs.p1 = {16{8'h20}}; rs.p2 = {16{8'h20}};
        rs.red = 0; rs.green = 0; rs.blue = 0; rs.err = 0; rs.msg = 0;
        compareSnap(rs, currentSnap());
    endtask

    task automatic enterApple();
        started = 1; expBlue = 1;
        tap(0, KEY_R0, "A");   hostWord = "A";    submitOk(0);
        tap(0, KEY_R2, "P");   hostWord = "AP";   submitOk(0);
        tap(0, KEY_R2, "P");   hostWord = "APP";  submitOk(0);
        tap(0, KEY_R1, "JKL"); hostWord = "APPL"; submitOk(0);
        tap(0, KEY_R0, "AE");  hostWord = "APPLE";
        expMsg = 1; inGuess = 1; guessStr = "_____"; missCh = "0";
        submitOk(0);
    endtask

    // Monitor: each change in the DUT outputs consumes one queued expectation.
    always @(negedge clk) begin
        snap_t nowSnap;
        nowSnap = currentSnap();
        if (!nRst) begin
            prevSnap = nowSnap;
        end else if (nowSnap != prevSnap) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_change: actual h1 \"%s\" h2 \"%s\" p1 \"%s\" p2 \"%s\" err %0d required no change at %0t",
                         nowSnap.h1, nowSnap.h2, nowSnap.p1, nowSnap.p2, nowSnap.err, $time);
            end else begin
                compareSnap(expQ.pop_front(), nowSnap);
            end
            prevSnap = nowSnap;
        end
    end

    // Stimulus: two games, one won and one lost, with entry corner cases along the way.
    initial begin
        nRst = 1'b0; role_switch = 1'b0; input_row_host = '0; input_row_player = '0;
        doReset();

        started = 1; expBlue = 1;
        tap(0, KEY_R0, "AEIOUA");
        tap(0, KEY_R1, "J");
        pend = 8'h20; pushExp(); flipRole(1'b1);
        tap(1, KEY_R0, "A");
        pend = 8'h20; pushExp(); flipRole(1'b0);
        applyStimulus(1, KEY_R0, HOLD);
        pushErr(); applyStimulus(0, KEY_R3, HOLD);

        enterApple();
        pend = "P"; pushExp(); applyStimulus(1, KEY_R2, 3000);
        guessStr = "_PP__"; submitOk(1);
        applyStimulus(0, KEY_R0, HOLD);
        tap(1, KEY_R2, "PQRSTVWXYZ"); missCh = "1"; submitOk(1);
        tap(1, KEY_R2, "PQRSTVWXYZ"); pend = 8'h20; pushErr(); applyStimulus(1, KEY_R3, HOLD);
        pushErr(); applyStimulus(1, KEY_R3, HOLD);
        tap(1, KEY_R0, "A");   guessStr = "APP__"; submitOk(1);
        tap(1, KEY_R1, "JKL"); guessStr = "APPL_"; submitOk(1);
        tap(1, KEY_R0, "AE");  guessStr = "APPLE"; expGreen = 1; expBlue = 0; submitOk(1);
        applyStimulus(1, KEY_R0, HOLD);
        applyStimulus(0, KEY_R1, HOLD);

        doReset();
        enterApple();
        tap(1, KEY_R0, "AEI");   missCh = "1"; submitOk(1);
        tap(1, KEY_R0, "AEIO");  missCh = "2"; submitOk(1);
        tap(1, KEY_R0, "AEIOU"); missCh = "3"; submitOk(1);
        tap(1, KEY_R1, "J");     missCh = "4"; submitOk(1);
        tap(1, KEY_R1, "JK");    missCh = "5"; submitOk(1);
        tap(1, KEY_R1, "JKLM");  missCh = "6"; guessStr = "APPLE"; expRed = 1; expBlue = 0;
        submitOk(1);
        applyStimulus(1, KEY_R2, HOLD);

        repeat (30) @(posedge clk);
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL pending_expectations: actual %0d outstanding required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
